// File: rtl/uop_queue_if.sv
// uop_queue_if: decode/dispatch-side bundle of the uop queue.
//
// Handshake semantics (both directions):
//   Enqueue: decode presents a group on enq_valid/enq_uop. The group is taken
//   at a clk edge when enq_ready=1 and flush=0; otherwise decode holds it.
//   enq_ready depends only on registered occupancy, never on deq_ack.
//   Dequeue: deq_valid/deq_uop show the two oldest entries (lane 0 older).
//   deq_ack consumes entries at the clk edge and must be a prefix of
//   deq_valid (2'b00, 2'b10, 2'b11).
//
// Signals:
//   enq_valid [0:1]        decode lane valids, lane 0 older
//   enq_uop   2 x UOP_W    decode lane payloads
//   enq_ready              queue can take a full 2-uop group
//   deq_valid [0:1]        head / head+1 valid
//   deq_uop   2 x UOP_W    head / head+1 payloads
//   deq_ack   [0:1]        entries consumed this cycle
//   flush                  exception flush, discards everything
//   count                  current occupancy
interface uop_queue_if #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [0:1]            enq_valid;
  logic [0:1][UOP_W-1:0] enq_uop;
  logic                  enq_ready;
  logic [0:1]            deq_valid;
  logic [0:1][UOP_W-1:0] deq_uop;
  logic [0:1]            deq_ack;
  logic                  flush;
  logic [CW-1:0]         count;

  // master = decode/dispatch side, slave = the queue
  modport master (
    output enq_valid, enq_uop, deq_ack, flush,
    input  enq_ready, deq_valid, deq_uop, count
  );

  modport slave (
    input  enq_valid, enq_uop, deq_ack, flush,
    output enq_ready, deq_valid, deq_uop, count
  );
endinterface

// File: rtl/uop_queue.sv
// uop_queue: 2-wide in-order circular buffer between decode and dispatch.
// Presents the two oldest uops to dispatch (lane 0 older than lane 1) and is
// cleared wholesale on flush.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   q      uop_queue_if.slave: enqueue group, dequeue pair, ack, flush, count
module uop_queue #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 64
) (
  input  logic clk,
  input  logic rst_n,
  uop_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [UOP_W-1:0] mem [DEPTH];

  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [PW-1:0] lane1_slot;
  logic          accept;
  logic          ack0;
  logic          ack1;
  logic [1:0]    n_enq;
  logic [1:0]    n_deq;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Registered count only: a same-cycle dequeue cannot raise enq_ready.
  assign q.enq_ready = (count <= CW'(DEPTH - 2));
  assign q.count     = count;

  assign q.deq_valid  = {count >= CW'(1), count >= CW'(2)};
  assign q.deq_uop[0] = mem[head];
  assign q.deq_uop[1] = mem[head_p1];

  assign accept = q.enq_ready & ~q.flush;
  assign n_enq  = accept ? ({1'b0, q.enq_valid[0]} + {1'b0, q.enq_valid[1]}) : 2'd0;

  // Acks are masked with deq_valid; lane 1 only counts behind lane 0, so a
  // 2'b01 ack degrades to no dequeue.
  assign ack0  = q.deq_ack[0] & q.deq_valid[0] & ~q.flush;
  assign ack1  = q.deq_ack[1] & q.deq_valid[1] & ack0;
  assign n_deq = {1'b0, ack0} + {1'b0, ack1};

  // Valid lanes are compacted: lane 1 lands at tail when lane 0 is idle.
  assign lane1_slot = q.enq_valid[0] ? tail_p1 : tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_deq);
      tail  <= tail + PW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Payload storage is not reset; entries are only read while valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (q.enq_valid[0]) mem[tail] <= q.enq_uop[0];
      if (q.enq_valid[1]) mem[lane1_slot] <= q.enq_uop[1];
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

  a_count_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    (count != CW'(DEPTH)) |-> (count == {1'b0, PW'(tail - head)}));

  a_ack_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !(q.deq_ack[1] && !q.deq_ack[0]) &&
    !(q.deq_ack[0] && !q.deq_valid[0]) &&
    !(q.deq_ack[1] && !q.deq_valid[1]));
endmodule

// File: tb/tb_uop_queue.sv
module tb_uop_queue;
  localparam int DEPTH = 8;
  localparam int UOP_W = 64;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // Reference model: the queue contents, oldest first.
  logic [UOP_W-1:0] exp_q[$];

  uop_queue_if #(.DEPTH(DEPTH), .UOP_W(UOP_W)) qi ();

  uop_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qi)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    int sz;
    sz = exp_q.size();
    check("count", 64'(qi.count), 64'(sz));
    check("enq_ready", 64'(qi.enq_ready), 64'(sz <= DEPTH - 2));
    check("deq_valid", 64'(qi.deq_valid), 64'({sz >= 1, sz >= 2}));
    if (sz >= 1) check("deq_uop0", qi.deq_uop[0], exp_q[0]);
    if (sz >= 2) check("deq_uop1", qi.deq_uop[1], exp_q[1]);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Applies one cycle of stimulus, advances the model by the queue's rules,
  // then samples the DUT 1ns after the edge.
  task automatic step(input logic [0:1] ev, input logic [63:0] u0, input logic [63:0] u1,
                      input logic [0:1] ack, input logic fl);
    bit accepted;
    int n_deq;
    qi.enq_valid  = ev;
    qi.enq_uop[0] = u0;
    qi.enq_uop[1] = u1;
    qi.deq_ack    = ack;
    qi.flush      = fl;
    accepted = (DEPTH - exp_q.size()) >= 2;
    n_deq = (ack == 2'b11) ? 2 : (ack == 2'b10) ? 1 : 0;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < n_deq; i++) void'(exp_q.pop_front());
      if (accepted) begin
        if (ev[0]) exp_q.push_back(u0);
        if (ev[1]) exp_q.push_back(u1);
      end
    end
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    qi.enq_valid  = 2'b00;
    qi.enq_uop[0] = '0;
    qi.enq_uop[1] = '0;
    qi.deq_ack    = 2'b00;
    qi.flush      = 1'b0;
  endtask

  // Asserts reset away from the clock edge, checks the immediate clear,
  // then releases on a falling edge.
  task automatic do_reset();
    idle_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_count", 64'(qi.count), 64'd0);
    check("rst_deq_valid", 64'(qi.deq_valid), 64'd0);
    check("rst_enq_ready", 64'(qi.enq_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [0:1] legal_ack(input bit greedy);
    int sz;
    int r;
    sz = exp_q.size();
    r = greedy ? $urandom_range(1, 2) : $urandom_range(0, 2);
    if (sz == 0) return 2'b00;
    if (sz == 1) return (r != 0) ? 2'b10 : 2'b00;
    return (r == 2) ? 2'b11 : (r == 1) ? 2'b10 : 2'b00;
  endfunction

  // ---------------- test sequence ----------------
  logic [63:0] a, b, x, y, z, saved;

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1;
    do_reset();

    // Basic 2-wide enqueue, visible next cycle.
    a = rnd64(); b = rnd64();
    step(2'b11, a, b, 2'b00, 1'b0);
    check("ab_valid", 64'(qi.deq_valid), 64'(2'b11));
    check("ab_uop0", qi.deq_uop[0], a);
    check("ab_uop1", qi.deq_uop[1], b);
    check("ab_count", 64'(qi.count), 64'd2);

    // Fill to full; a fifth group is ignored; draining restores enq_ready.
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b11, rnd64(), rnd64(), 2'b00, 1'b0);
    check("full_count", 64'(qi.count), 64'd8);
    check("full_ready", 64'(qi.enq_ready), 64'd0);
    step(2'b11, rnd64(), rnd64(), 2'b00, 1'b0);
    check("full_ignored", 64'(qi.count), 64'd8);
    step(2'b00, 64'd0, 64'd0, 2'b11, 1'b0);
    check("drain_count", 64'(qi.count), 64'd6);
    check("drain_ready", 64'(qi.enq_ready), 64'd1);

    // Group straddling the wrap: move head and tail to slot 7 first.
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, rnd64(), rnd64(), 2'b00, 1'b0);
    step(2'b10, rnd64(), rnd64(), 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, 64'd0, 64'd0, 2'b11, 1'b0);
    step(2'b00, 64'd0, 64'd0, 2'b10, 1'b0);
    check("wrap_empty", 64'(qi.count), 64'd0);
    x = rnd64(); y = rnd64();
    step(2'b11, x, y, 2'b00, 1'b0);
    check("wrap_x", qi.deq_uop[0], x);
    check("wrap_y", qi.deq_uop[1], y);
    step(2'b00, 64'd0, 64'd0, 2'b10, 1'b0);
    check("wrap_y_head", qi.deq_uop[0], y);

    // Simultaneous enqueue and dequeue.
    do_reset();
    step(2'b11, rnd64(), rnd64(), 2'b00, 1'b0);
    saved = exp_q[1];
    step(2'b10, rnd64(), rnd64(), 2'b00, 1'b0);
    step(2'b11, rnd64(), rnd64(), 2'b10, 1'b0);
    check("simul_count", 64'(qi.count), 64'd4);
    check("simul_head", qi.deq_uop[0], saved);

    // Flush wins over a same-cycle enqueue.
    do_reset();
    step(2'b11, rnd64(), rnd64(), 2'b00, 1'b0);
    step(2'b11, rnd64(), rnd64(), 2'b00, 1'b0);
    step(2'b10, rnd64(), rnd64(), 2'b00, 1'b0);
    check("pre_flush_count", 64'(qi.count), 64'd5);
    step(2'b11, rnd64(), rnd64(), 2'b00, 1'b1);
    check("flush_count", 64'(qi.count), 64'd0);
    check("flush_valid", 64'(qi.deq_valid), 64'd0);
    check("flush_ready", 64'(qi.enq_ready), 64'd1);

    // Lane-1-only enqueue compacts into the head slot.
    do_reset();
    z = rnd64();
    step(2'b01, rnd64(), z, 2'b00, 1'b0);
    check("lane1_valid", 64'(qi.deq_valid), 64'(2'b10));
    check("lane1_uop0", qi.deq_uop[0], z);
    check("lane1_count", 64'(qi.count), 64'd1);

    // Randomized traffic with alternating fill/drain bias and rare flushes.
    for (int i = 0; i < 600; i++) begin
      bit drain;
      logic [0:1] ev;
      drain = ((i / 40) % 2) == 1;
      ev = 2'($urandom_range(0, 3));
      if (drain && $urandom_range(0, 2) != 0) ev = 2'b00;
      step(ev, rnd64(), rnd64(), legal_ack(drain), ($urandom_range(0, 40) == 0));
      if (i == 300) begin
        // Asynchronous reset in the middle of traffic.
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
